// File: rtl/soc_err_event_logger.sv
// SoC error event logger: timestamps error events into a FIFO drained over a zero-wait APB4 slave.
// Latency: event detected 1 cycle after the inputs change, pushed at the end of that cycle; irq 1 cycle after the FIFO/irq_en change.
// Backpressure: none upstream; a full FIFO drops the event and bumps ovf_cnt. Optional feature macro: ERR_LOG_FREEZE_EN (CTRL[2] freeze).
module soc_err_event_logger #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 16
) (
    input  logic        clk_sys,
    input  logic        rst_sys_n,
    input  logic        soc_error,
    input  logic [3:0]  err_code,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [7:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        irq_err_log
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [3:0]      code;
        logic [TS_W-1:0] ts;
    } entry_t;

    logic [TS_W-1:0] ts;
    logic            err_q;
    logic [3:0]      code_q;
    logic            prev_err;
    logic [3:0]      prev_code;
    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [7:0]      ovf_cnt;
    logic            irq_en;
    logic            freeze;

    logic            empty;
    logic            full;
    logic            evt;
    logic            pop;
    logic            push;
    logic            drop;
    logic            ctrl_wr;
    entry_t          head;

    assign pready = 1'b1;
    assign empty  = (count == '0);
    assign full   = (count == FULL_CNT);
    assign head   = mem[rd_ptr];
    // A new rise of the error, or a code change while it stays asserted.
    assign evt    = err_q & (~prev_err | (code_q != prev_code));
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push   = evt & ~freeze & (~full | pop);
    assign drop   = evt & ~freeze & full & ~pop;

    // APB access decode: combinational read data, error response and side-effect strobes.
    always_comb begin
        prdata  = '0;
        pslverr = 1'b0;
        pop     = 1'b0;
        ctrl_wr = 1'b0;
        if (psel && penable) begin
            case (paddr[7:2])
                6'd0: begin
                    if (pwrite) pslverr = 1'b1;
                    else        prdata  = {16'b0, ovf_cnt, 4'(count), 2'b0, full, empty};
                end
                6'd1: begin
                    if (pwrite || empty) begin
                        pslverr = 1'b1;
                    end else begin
                        prdata = {1'b1, 11'b0, head.code, 16'(head.ts)};
                        pop    = 1'b1;
                    end
                end
                6'd2: begin
                    if (pwrite) ctrl_wr = 1'b1;
                    else        prdata  = {29'b0, freeze, 1'b0, irq_en};
                end
                6'd3: begin
                    if (pwrite) pslverr = 1'b1;
                    else        prdata  = 32'(ts);
                end
                default: pslverr = 1'b1;
            endcase
        end
    end

`ifdef ERR_LOG_FREEZE_EN
    // Freeze bit: software-controlled suppression of event capture.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n)   freeze <= 1'b0;
        else if (ctrl_wr) freeze <= pwdata[2];
    end
`else
    assign freeze = 1'b0;
`endif

    // Bits of the bus that carry no meaning for this block.
    logic unused_bits;
    assign unused_bits = ^{pwdata[31:2], paddr[1:0]};

    // Timestamp, input registers and edge/change history.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            ts        <= '0;
            err_q     <= 1'b0;
            code_q    <= '0;
            prev_err  <= 1'b0;
            prev_code <= '0;
        end else begin
            ts        <= ts + 1'b1;
            err_q     <= soc_error;
            code_q    <= err_code;
            prev_err  <= err_q;
            prev_code <= code_q;
        end
    end

    // FIFO storage; pointers below define which entries are live.
    always_ff @(posedge clk_sys) begin
        if (push) mem[wr_ptr] <= '{code: code_q, ts: ts};
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Control, saturating overflow counter (clear beats increment) and registered interrupt.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            ovf_cnt     <= '0;
            irq_en      <= 1'b0;
            irq_err_log <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en <= pwdata[0];
            if (ctrl_wr && pwdata[1])        ovf_cnt <= '0;
            else if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 1'b1;
            irq_err_log <= irq_en & ~empty;
        end
    end

endmodule

// File: doc/soc_err_event_logger.md
Name: soc_err_event_logger

Overview:
- Downstream consumer of the SoC error-priority encoder outputs (soc_error, err_code).
- Timestamps each new error event and queues it in a small FIFO.
- Software drains the FIFO over a zero-wait APB4 slave port on the peripheral bus.
- Raises a level interrupt while undrained entries exist.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..8
TS_W, 16, timestamp counter width; 8..16

Ports:
clk_sys  in  1  system clock
rst_sys_n  in  1  asynchronous active-low reset
soc_error  in  1  SoC error active (level)
err_code  in  4  encoded error cause, valid while soc_error=1
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  APB write
paddr  in  8  APB byte address; bits [1:0] ignored
pwdata  in  32  APB write data
prdata  out  32  APB read data
pready  out  1  APB ready, tied 1
pslverr  out  1  APB error response
irq_err_log  out  1  interrupt, registered

Behaviour:
- Clock and reset: one clock, clk_sys; reset rst_sys_n is asynchronous, active-low.
- Reset values: prdata=0, pslverr=0, irq_err_log=0, FIFO empty, timestamp=0, ovf_cnt=0, irq_en=0, previous-code register=0, previous-error register=0.
- Timestamp: free-running TS_W counter, +1 every cycle; wraps from all-ones to 0.
- Event detection: soc_error and err_code are registered once, so event detection lags the inputs by 1 cycle. An event is detected when either:
  - registered soc_error rises 0->1, or
  - soc_error stays 1 and registered err_code differs from the previous code.
- Event capture: entry = {code[3:0], timestamp sampled in the detection cycle}.
- Push: in the detection cycle, if the FIFO is not full.
- Full FIFO on event: entry dropped; ovf_cnt (8-bit) increments and saturates at 255.
- Same-cycle push and pop:
  - both occur; count is unchanged;
  - when full, the pop frees the slot, so nothing is dropped;
  - when empty, the pop returns 0 with pslverr=1, and the push still lands.
- APB: access phase is psel&penable; pready=1 always; prdata/pslverr are combinational during the access phase and 0 otherwise. Register map:
  - 0x00 STATUS (RO): [0] empty, [1] full, [7:4] count, [15:8] ovf_cnt, others 0.
  - 0x04 DATA (RO): [TS_W-1:0] timestamp, [19:16] code, [31] valid=1. A read pops one entry.
    - Read when empty: prdata=0, pslverr=1, no pop.
  - 0x08 CTRL (RW): [0] irq_en; [1] W1C-style pulse that clears ovf_cnt (reads 0).
    - Clear and an overflow increment in the same cycle: the clear wins.
  - 0x0C TSNOW (RO): current timestamp.
  - Error responses with pslverr=1, no side effects: any write to 0x00, 0x04, 0x0C; any access to another address.
- Interrupt: irq_err_log is registered: next value = irq_en & ~empty, so it updates 1 cycle after the FIFO or irq_en changes.
- Reset mid-operation clears all state at once; a pending APB read completes with 0.

Optional Feature:
- Macro ERR_LOG_FREEZE_EN.
- Defined:
  - CTRL[2] is RW freeze.
  - While freeze=1, events are neither pushed nor counted as overflow.
  - Timestamp keeps running; DATA pops still work.
  - An error still active at unfreeze is not re-detected unless its code changes.
- Undefined: CTRL[2] reads 0 and writes are ignored.

Test Plan:
- Reset, then read STATUS -> 0x00000001; read DATA -> prdata=0, pslverr=1; irq_err_log=0.
- soc_error rises with err_code=0x2 while timestamp=T-1 (the event is detected one cycle later, when timestamp=T) -> DATA read returns 0x80020000|T and STATUS count goes 1->0.
- soc_error held 1, err_code 0x1 -> 0x5 -> 0x5 -> 0x6 -> exactly 3 entries, codes 1, 5, 6 in order; falling then rising soc_error with code 6 -> 4th entry.
- With DEPTH=8, generate 10 events without reads -> STATUS full=1, count=8, ovf_cnt=2; write CTRL=0x2 -> ovf_cnt=0; at full, a DATA read coinciding with an event -> count stays 8, ovf unchanged.
- CTRL irq_en=1 with 1 entry queued -> irq_err_log=1 one cycle after the write; pop the last entry -> irq_err_log=0 one cycle later.
- Write to 0x04 and read from 0x10 -> pslverr=1, state unchanged; with ERR_LOG_FREEZE_EN defined, set CTRL[2]=1 and raise 3 events -> count=0, ovf_cnt=0.
